riscv_csr_file: RTL and testbench

//  Machine-mode CSR register file serving riscv_core's CSR port (csr_rd/csr_wr).

---
 rtl/riscv_csr_file_if.sv | 20 ++
 rtl/riscv_csr_file.sv | 147 ++++++++++++++
 tb/tb_riscv_csr_file.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_csr_file_if.sv
// CSR access port between riscv_core (master) and the machine-mode CSR file (slave).
interface riscv_csr_file_if;
  logic        csr_rd;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_wr;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        csr_illegal;

  modport master (
    output csr_rd, csr_rd_addr, csr_wr, csr_wr_addr, csr_wr_data,
    input  csr_rd_data, csr_illegal
  );

  modport slave (
    input  csr_rd, csr_rd_addr, csr_wr, csr_wr_addr, csr_wr_data,
    output csr_rd_data, csr_illegal
  );
endinterface

// File: rtl/riscv_csr_file.sv
// Machine-mode CSR file: trap/interrupt state, 64-bit cycle/instret counters,
// read-only ID registers, and the registered external-interrupt request.
module riscv_csr_file #(
  parameter int              XLEN      = 32,
  parameter logic [31:0]     HARTID    = 32'h0,
  parameter logic [31:0]     MISA_VAL  = 32'h40000100,
  parameter logic [31:0]     MTVEC_RST = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  riscv_csr_file_if.slave   bus,
  input  logic              instr_retired,
  input  logic              EIP,
  input  logic              trap_take,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic              mret,
  output logic              irq_req,
  output logic [XLEN-1:0]   mtvec_o,
  output logic [XLEN-1:0]   mepc_o
);

  // Only the architecturally implemented bits are stored; the rest read as 0.
  logic            mie_bit_reg;    // mstatus.MIE
  logic            mpie_bit_reg;   // mstatus.MPIE
  logic            meie_reg;       // mie.MEIE
  logic [XLEN-1:0] mtvec_reg;
  logic [XLEN-1:0] mscratch_reg;
  logic [XLEN-1:0] mepc_reg;
  logic [XLEN-1:0] mcause_reg;
  logic            irq_req_reg;

  logic [63:0]     cnt_val [2];    // [0] = mcycle, [1] = minstret

  logic            wr_300, wr_304, wr_305, wr_340, wr_341, wr_342;

  assign wr_300 = bus.csr_wr && (bus.csr_wr_addr == 12'h300);
  assign wr_304 = bus.csr_wr && (bus.csr_wr_addr == 12'h304);
  assign wr_305 = bus.csr_wr && (bus.csr_wr_addr == 12'h305);
  assign wr_340 = bus.csr_wr && (bus.csr_wr_addr == 12'h340);
  assign wr_341 = bus.csr_wr && (bus.csr_wr_addr == 12'h341);
  assign wr_342 = bus.csr_wr && (bus.csr_wr_addr == 12'h342);

  // Trap state: trap_take beats mret, which beats a CSR write to the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mie_bit_reg  <= 1'b0;
      mpie_bit_reg <= 1'b0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
    end else if (trap_take) begin
      mepc_reg     <= trap_pc;
      mcause_reg   <= trap_cause;
      mpie_bit_reg <= mie_bit_reg;
      mie_bit_reg  <= 1'b0;
    end else if (mret) begin
      mie_bit_reg  <= mpie_bit_reg;
      mpie_bit_reg <= 1'b1;
    end else begin
      if (wr_300) begin
        mie_bit_reg  <= bus.csr_wr_data[3];
        mpie_bit_reg <= bus.csr_wr_data[7];
      end
      if (wr_341) mepc_reg   <= bus.csr_wr_data;
      if (wr_342) mcause_reg <= bus.csr_wr_data;
    end
  end

  // Plain read/write CSRs that traps never touch.
  always_ff @(posedge clk) begin
    if (reset) begin
      meie_reg     <= 1'b0;
      mtvec_reg    <= MTVEC_RST;
      mscratch_reg <= '0;
    end else begin
      if (wr_304) meie_reg     <= bus.csr_wr_data[11];
      if (wr_305) mtvec_reg    <= bus.csr_wr_data;
      if (wr_340) mscratch_reg <= bus.csr_wr_data;
    end
  end

  // Interrupt request is registered from the current enables, so it lags a
  // trap-induced MIE clear by one cycle.
  always_ff @(posedge clk) begin
    if (reset) irq_req_reg <= 1'b0;
    else       irq_req_reg <= EIP && meie_reg && mie_bit_reg;
  end

  // Two 64-bit counters sharing one structure; a CSR write to one half wins for
  // that half while the other half still takes the normal increment/carry.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      localparam logic [11:0] LO_ADDR = (gi == 0) ? 12'hB00 : 12'hB02;
      localparam logic [11:0] HI_ADDR = LO_ADDR + 12'h080;
      logic        step;
      logic [63:0] cnt_reg;
      logic [63:0] cnt_next;

      assign step = (gi == 0) ? 1'b1 : instr_retired;

      // Increment, then overlay any same-cycle write per half.
      always_comb begin
        cnt_next = cnt_reg + {63'b0, step};
        if (bus.csr_wr && (bus.csr_wr_addr == LO_ADDR)) cnt_next[31:0]  = bus.csr_wr_data;
        if (bus.csr_wr && (bus.csr_wr_addr == HI_ADDR)) cnt_next[63:32] = bus.csr_wr_data;
      end

      // Counter register.
      always_ff @(posedge clk) begin
        if (reset) cnt_reg <= '0;
        else       cnt_reg <= cnt_next;
      end

      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  // Combinational read mux; always reflects pre-edge state.
  always_comb begin
    logic mapped;
    mapped          = 1'b1;
    bus.csr_rd_data = '0;
    case (bus.csr_rd_addr)
      12'h300: bus.csr_rd_data = {19'b0, 2'b11, 3'b0, mpie_bit_reg, 3'b0, mie_bit_reg, 3'b0};
      12'h301: bus.csr_rd_data = MISA_VAL;
      12'h304: bus.csr_rd_data = {20'b0, meie_reg, 11'b0};
      12'h305: bus.csr_rd_data = mtvec_reg;
      12'h340: bus.csr_rd_data = mscratch_reg;
      12'h341: bus.csr_rd_data = mepc_reg;
      12'h342: bus.csr_rd_data = mcause_reg;
      12'h344: bus.csr_rd_data = {20'b0, EIP, 11'b0};
      12'hB00, 12'hC00: bus.csr_rd_data = cnt_val[0][31:0];
      12'hB80, 12'hC80: bus.csr_rd_data = cnt_val[0][63:32];
      12'hB02, 12'hC02: bus.csr_rd_data = cnt_val[1][31:0];
      12'hB82, 12'hC82: bus.csr_rd_data = cnt_val[1][63:32];
      12'hF14: bus.csr_rd_data = HARTID;
      default: mapped = 1'b0;
    endcase
    bus.csr_illegal = bus.csr_rd && !mapped;
  end

  assign irq_req = irq_req_reg;
  assign mtvec_o = {mtvec_reg[XLEN-1:2], 2'b00};
  assign mepc_o  = {mepc_reg[XLEN-1:2], 2'b00};

endmodule

// File: tb/tb_riscv_csr_file.sv
// Directed self-checking bench for riscv_csr_file.
module tb_riscv_csr_file;
  logic        clk = 1'b0;
  logic        reset;
  logic        instr_retired;
  logic        EIP;
  logic        trap_take;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        mret;
  logic        irq_req;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;

  int n_checks = 0;
  int n_err    = 0;

  riscv_csr_file_if bus ();

  riscv_csr_file #(
    .XLEN      (32),
    .HARTID    (32'h3),
    .MISA_VAL  (32'h40000100),
    .MTVEC_RST (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .instr_retired (instr_retired),
    .EIP           (EIP),
    .trap_take     (trap_take),
    .trap_pc       (trap_pc),
    .trap_cause    (trap_cause),
    .mret          (mret),
    .irq_req       (irq_req),
    .mtvec_o       (mtvec_o),
    .mepc_o        (mepc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Combinational read of one CSR, settled away from the clock edge.
  task automatic rd(input logic [11:0] addr, output logic [31:0] data);
    bus.csr_rd      = 1'b1;
    bus.csr_rd_addr = addr;
    #1;
    data = bus.csr_rd_data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d;

  initial begin
    reset = 1'b1; instr_retired = 1'b0; EIP = 1'b0; trap_take = 1'b0;
    trap_pc = '0; trap_cause = '0; mret = 1'b0;
    bus.csr_rd = 1'b0; bus.csr_rd_addr = '0;
    bus.csr_wr = 1'b0; bus.csr_wr_addr = '0; bus.csr_wr_data = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    rd(12'h300, d); chk("rst_mstatus", d, 32'h1800);
    chk("rst_illegal", {31'b0, bus.csr_illegal}, 32'h0);
    rd(12'h344, d); chk("rst_mip", d, 32'h0);
    rd(12'hF14, d); chk("rst_mhartid", d, 32'h3);
    rd(12'hB00, d); chk("rst_mcycle", d, 32'h0);
    chk("rst_irq", {31'b0, irq_req}, 32'h0);
    chk("rst_mtvec_o", mtvec_o, 32'h0);
    tick();
    rd(12'hB00, d); chk("mcycle_inc", d, 32'h1);

    // mtvec write, read back full, output masked
    bus.csr_wr = 1'b1; bus.csr_wr_addr = 12'h305; bus.csr_wr_data = 32'h80000103;
    tick();
    bus.csr_wr = 1'b0;
    rd(12'h305, d); chk("mtvec_rd", d, 32'h80000103);
    chk("mtvec_o", mtvec_o, 32'h80000100);

    // Same-cycle read returns old value
    bus.csr_wr = 1'b1; bus.csr_wr_addr = 12'h340; bus.csr_wr_data = 32'h0000AAAA;
    rd(12'h340, d); chk("mscratch_old", d, 32'h0);
    tick();
    bus.csr_wr = 1'b0;
    rd(12'h340, d); chk("mscratch_new", d, 32'h0000AAAA);

    // mcycle write and carry into the high word
    bus.csr_wr = 1'b1; bus.csr_wr_addr = 12'hB00; bus.csr_wr_data = 32'hFFFFFFFE;
    tick();
    bus.csr_wr_addr = 12'hB80; bus.csr_wr_data = 32'h5;
    tick();
    bus.csr_wr = 1'b0;
    rd(12'hB00, d); chk("mcycle_lo_ff", d, 32'hFFFFFFFF);
    rd(12'hB80, d); chk("mcycle_hi_5", d, 32'h5);
    tick();
    rd(12'hB00, d); chk("mcycle_lo_wrap", d, 32'h0);
    rd(12'hB80, d); chk("mcycle_hi_carry", d, 32'h6);
    rd(12'hC80, d); chk("cycleh_shadow", d, 32'h6);
    // Write to the read-only shadow is dropped
    bus.csr_wr = 1'b1; bus.csr_wr_addr = 12'hC00; bus.csr_wr_data = 32'h1234;
    tick();
    bus.csr_wr = 1'b0;
    rd(12'hB00, d); chk("cycle_ro_drop", d, 32'h1);

    // minstret counting, written value wins over increment
    instr_retired = 1'b1;
    tick(); tick(); tick();
    instr_retired = 1'b0;
    rd(12'hB02, d); chk("minstret_3", d, 32'h3);
    instr_retired = 1'b1;
    bus.csr_wr = 1'b1; bus.csr_wr_addr = 12'hB02; bus.csr_wr_data = 32'hFFFFFFFF;
    tick();
    bus.csr_wr = 1'b0;
    rd(12'hB02, d); chk("minstret_wr_wins", d, 32'hFFFFFFFF);
    rd(12'hB82, d); chk("minstreth_0", d, 32'h0);
    tick();
    instr_retired = 1'b0;
    rd(12'hC02, d); chk("instret_wrap", d, 32'h0);
    rd(12'hB82, d); chk("minstreth_carry", d, 32'h1);

    // Interrupt enable and request
    bus.csr_wr = 1'b1; bus.csr_wr_addr = 12'h304; bus.csr_wr_data = 32'hFFFFFFFF;
    tick();
    bus.csr_wr_addr = 12'h300; bus.csr_wr_data = 32'h8;
    tick();
    bus.csr_wr = 1'b0;
    rd(12'h304, d); chk("mie_warl", d, 32'h800);
    rd(12'h300, d); chk("mstatus_mie", d, 32'h1808);
    EIP = 1'b1;
    rd(12'h344, d); chk("mip_meip", d, 32'h800);
    chk("irq_not_yet", {31'b0, irq_req}, 32'h0);
    tick();
    chk("irq_set", {31'b0, irq_req}, 32'h1);

    // Trap entry with a competing mepc write
    trap_take = 1'b1; trap_pc = 32'h100; trap_cause = 32'h8000000B;
    bus.csr_wr = 1'b1; bus.csr_wr_addr = 12'h341; bus.csr_wr_data = 32'hDEAD0000;
    tick();
    trap_take = 1'b0; bus.csr_wr = 1'b0;
    rd(12'h341, d); chk("trap_mepc", d, 32'h100);
    rd(12'h342, d); chk("trap_mcause", d, 32'h8000000B);
    rd(12'h300, d); chk("trap_mstatus", d, 32'h1880);
    chk("trap_mepc_o", mepc_o, 32'h100);
    chk("irq_lag", {31'b0, irq_req}, 32'h1);
    tick();
    chk("irq_drop", {31'b0, irq_req}, 32'h0);

    // MRET restores MIE
    mret = 1'b1;
    tick();
    mret = 1'b0;
    rd(12'h300, d); chk("mret_mstatus", d, 32'h1888);
    tick();
    chk("irq_again", {31'b0, irq_req}, 32'h1);

    // trap_take and mret together: trap only
    trap_take = 1'b1; mret = 1'b1; trap_pc = 32'h203; trap_cause = 32'h3;
    tick();
    trap_take = 1'b0; mret = 1'b0; EIP = 1'b0;
    rd(12'h300, d); chk("trap_mret_mstatus", d, 32'h1880);
    chk("mepc_o_mask", mepc_o, 32'h200);
    rd(12'h341, d); chk("mepc_full", d, 32'h203);

    // Illegal address and RO misa
    rd(12'h7C0, d); chk("illegal_data", d, 32'h0);
    chk("illegal_flag", {31'b0, bus.csr_illegal}, 32'h1);
    bus.csr_rd = 1'b0; #1;
    chk("illegal_no_rd", {31'b0, bus.csr_illegal}, 32'h0);
    bus.csr_wr = 1'b1; bus.csr_wr_addr = 12'h301; bus.csr_wr_data = 32'h0;
    tick();
    bus.csr_wr = 1'b0;
    rd(12'h301, d); chk("misa_ro", d, 32'h40000100);

    // Reset mid-operation discards a concurrent write
    reset = 1'b1;
    bus.csr_wr = 1'b1; bus.csr_wr_addr = 12'h340; bus.csr_wr_data = 32'h5;
    tick();
    reset = 1'b0; bus.csr_wr = 1'b0;
    rd(12'h340, d); chk("rst2_mscratch", d, 32'h0);
    rd(12'h300, d); chk("rst2_mstatus", d, 32'h1800);
    rd(12'h305, d); chk("rst2_mtvec", d, 32'h0);
    rd(12'hB80, d); chk("rst2_mcycleh", d, 32'h0);
    chk("rst2_irq", {31'b0, irq_req}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
